// File: rtl/t_flip_flop_pkg.sv
// Shared constants and helpers for the toggle flip-flop bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake in this block).
package t_flip_flop_pkg;

  // Default and largest supported number of toggle bits
  localparam int TFF_DEFAULT_WIDTH = 1;
  localparam int TFF_MAX_WIDTH     = 64;

  // Reset vector sized for the widest supported bank; callers truncate it
  typedef logic [TFF_MAX_WIDTH-1:0] tff_vec_t;

  // Default reset state of every bit is 0
  function automatic tff_vec_t tff_default_reset();
    return '0;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit toggle flip-flop with synchronous active-low reset and toggle flag.
// Latency: one cycle; t sampled at edge N is reflected on q/toggled right after edge N.
// Backpressure: none; a toggle request is accepted on every rising clk edge.
module tff_cell (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  input  logic rst_val,
  output logic q,
  output logic toggled
);

  // Reset takes priority over any toggle request on the same edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q       <= rst_val;
      toggled <= 1'b0;
    end else begin
      q       <= q ^ t;
      toggled <= t;
    end
  end

endmodule

// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent toggle flip-flops with complement output and toggle flags.
// Latency: one cycle from t sampled on a rising clk to q/toggled; qn follows q combinationally.
// Backpressure: none; every bit accepts a toggle request on every rising clk edge.
module t_flip_flop
  import t_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = TFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(tff_default_reset())
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] toggled
);

  // One cell per bit; bits share only clock and reset
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_cell (
      .clk     (clk),
      .rstn    (rstn),
      .t       (t[i]),
      .rst_val (RESET_VALUE[i]),
      .q       (q[i]),
      .toggled (toggled[i])
    );
  end

  // Complement is purely combinational so it tracks q even while in reset
  assign qn = ~q;

endmodule

// File: tb/tb_t_flip_flop.sv
module tb_t_flip_flop;

  localparam logic [3:0] RV4 = 4'b1010;

  logic       clk = 1'b0;
  logic       rstn;
  logic [0:0] t1;
  logic [3:0] t4;
  logic [0:0] q1, qn1, tg1;
  logic [3:0] q4, qn4, tg4;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: number of toggles each bit has seen since its last reset
  int         cnt1;
  int         cnt4 [4];
  logic [0:0] tog1_exp;
  logic [3:0] tog4_exp;

  always #5 clk = ~clk;

  t_flip_flop dut1 (
    .clk     (clk),
    .rstn    (rstn),
    .t       (t1),
    .q       (q1),
    .qn      (qn1),
    .toggled (tg1)
  );

  t_flip_flop #(.WIDTH(4), .RESET_VALUE(RV4)) dut4 (
    .clk     (clk),
    .rstn    (rstn),
    .t       (t4),
    .q       (q4),
    .qn      (qn4),
    .toggled (tg4)
  );

  // Expected state = reset value flipped by the parity of the toggle count
  function automatic logic [0:0] exp_q1();
    return 1'((cnt1 % 2) == 1);
  endfunction

  function automatic logic [3:0] exp_q4();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = RV4[i] ^ ((cnt4[i] % 2) == 1);
    return r;
  endfunction

  // Drive one set of inputs across one rising edge, update the model, land at edge+1
  task automatic step(input logic r, input logic [0:0] a, input logic [3:0] b);
    rstn = r;
    t1   = a;
    t4   = b;
    @(posedge clk);
    if (!r) begin
      cnt1 = 0;
      for (int i = 0; i < 4; i++) cnt4[i] = 0;
      tog1_exp = '0;
      tog4_exp = '0;
    end else begin
      cnt1 += int'(a);
      for (int i = 0; i < 4; i++) cnt4[i] += int'(b[i]);
      tog1_exp = a;
      tog4_exp = b;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 4'b0000);
      vectors++;
      if (q1 !== 1'b0 || qn1 !== 1'b1 || tg1 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_w1 edge%0d: q=%b qn=%b tog=%b, want q=0 qn=1 tog=0", k, q1, qn1, tg1);
      end
      vectors++;
      if (q4 !== 4'b1010 || qn4 !== 4'b0101 || tg4 !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_w4 edge%0d: q=%b qn=%b tog=%b, want q=1010 qn=0101 tog=0000", k, q4, qn4, tg4);
      end
    end
  endtask

  task automatic test_toggle_seq();
    logic [0:0] seq [4];
    seq = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 4'b1111);
      vectors++;
      if (q1 !== seq[k] || tg1 !== 1'b1 || qn1 !== ~seq[k]) begin
        miscompares++;
        $display("FAIL toggle_seq step%0d: q=%b qn=%b tog=%b, want q=%b tog=1", k, q1, qn1, tg1, seq[k]);
      end
      vectors++;
      if (q4 !== exp_q4() || tg4 !== 4'b1111) begin
        miscompares++;
        $display("FAIL toggle_seq_w4 step%0d: q=%b tog=%b, want q=%b tog=1111", k, q4, tg4, exp_q4());
      end
    end
  endtask

  task automatic test_hold();
    logic [0:0] q1_start;
    logic [3:0] q4_start;
    q1_start = exp_q1();
    q4_start = exp_q4();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 4'b0000);
      vectors++;
      if (q1 !== q1_start || tg1 !== 1'b0 || q4 !== q4_start || tg4 !== 4'b0000) begin
        miscompares++;
        $display("FAIL hold step%0d: q1=%b tg1=%b q4=%b tg4=%b, want q1=%b tg1=0 q4=%b tg4=0000",
                 k, q1, tg1, q4, tg4, q1_start, q4_start);
      end
    end
  endtask

  task automatic test_glitch();
    step(1'b1, 1'b0, 4'b0000);
    for (int n = 0; n < 10; n++) begin
      int d;
      int ph;
      int room;
      d = int'($urandom_range(0, 31));
      if ((6 + d) % 10 == 5) d++;
      #(d);
      ph   = int'($time % 10);
      room = (ph < 5) ? (5 - ph) : (15 - ph);
      if (room >= 3) begin
        t1 = 1'b1;
        t4 = 4'b1111;
        #(int'($urandom_range(1, room - 2)));
        t1 = 1'b0;
        t4 = 4'b0000;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (q1 !== exp_q1() || tg1 !== 1'b0 || q4 !== exp_q4() || tg4 !== 4'b0000) begin
        miscompares++;
        $display("FAIL glitch n%0d: q1=%b tg1=%b q4=%b tg4=%b, want q1=%b tg1=0 q4=%b tg4=0000",
                 n, q1, tg1, q4, tg4, exp_q1(), exp_q4());
      end
    end
    // A level present at exactly one edge toggles exactly once
    step(1'b1, 1'b1, 4'b0101);
    step(1'b1, 1'b0, 4'b0000);
    vectors++;
    if (q1 !== exp_q1() || q4 !== exp_q4() || tg4 !== 4'b0000) begin
      miscompares++;
      $display("FAIL level_once: q1=%b q4=%b tg4=%b, want q1=%b q4=%b tg4=0000",
               q1, q4, tg4, exp_q1(), exp_q4());
    end
  endtask

  task automatic test_reset_dominance();
    if (exp_q1() !== 1'b1) step(1'b1, 1'b1, 4'b0000);
    vectors++;
    if (q1 !== 1'b1) begin
      miscompares++;
      $display("FAIL dom_setup: q=%b, want 1", q1);
    end
    step(1'b0, 1'b1, 4'b1111);
    vectors++;
    if (q1 !== 1'b0 || tg1 !== 1'b0 || q4 !== 4'b1010 || tg4 !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_wins: q1=%b tg1=%b q4=%b tg4=%b, want q1=0 tg1=0 q4=1010 tg4=0000",
               q1, tg1, q4, tg4);
    end
    step(1'b1, 1'b1, 4'b0000);
    vectors++;
    if (q1 !== 1'b1 || tg1 !== 1'b1) begin
      miscompares++;
      $display("FAIL first_after_reset: q=%b tog=%b, want q=1 tog=1", q1, tg1);
    end
  endtask

  task automatic test_width4();
    step(1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 4'b0110);
    vectors++;
    if (q4 !== 4'b1100 || tg4 !== 4'b0110 || qn4 !== 4'b0011) begin
      miscompares++;
      $display("FAIL width4: q=%b tog=%b qn=%b, want q=1100 tog=0110 qn=0011", q4, tg4, qn4);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 4'b1001);
    rstn = 1'b0;
    t1   = 1'b0;
    t4   = 4'b0000;
    #2;
    vectors++;
    if (q1 !== exp_q1() || q4 !== exp_q4() || tg4 !== 4'b1001) begin
      miscompares++;
      $display("FAIL no_async_reset: q1=%b q4=%b tg4=%b, want q1=%b q4=%b tg4=1001",
               q1, q4, tg4, exp_q1(), exp_q4());
    end
    @(posedge clk);
    cnt1 = 0;
    for (int i = 0; i < 4; i++) cnt4[i] = 0;
    tog1_exp = '0;
    tog4_exp = '0;
    #1;
    vectors++;
    if (q4 !== 4'b1010 || qn4 !== 4'b0101 || q1 !== 1'b0 || tg4 !== 4'b0000) begin
      miscompares++;
      $display("FAIL sync_reset_edge: q1=%b q4=%b qn4=%b tg4=%b, want q1=0 q4=1010 qn4=0101 tg4=0000",
               q1, q4, qn4, tg4);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      logic       r;
      logic [0:0] a;
      logic [3:0] b;
      r = ($urandom_range(0, 9) != 0);
      a = 1'($urandom_range(0, 1));
      b = 4'($urandom_range(0, 15));
      step(r, a, b);
      vectors++;
      if (q1 !== exp_q1() || qn1 !== ~exp_q1() || tg1 !== tog1_exp ||
          q4 !== exp_q4() || qn4 !== ~exp_q4() || tg4 !== tog4_exp) begin
        miscompares++;
        $display("FAIL random k%0d: q1=%b qn1=%b tg1=%b q4=%b qn4=%b tg4=%b, want q1=%b tg1=%b q4=%b tg4=%b",
                 k, q1, qn1, tg1, q4, qn4, tg4, exp_q1(), tog1_exp, exp_q4(), tog4_exp);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    t1   = 1'b0;
    t4   = 4'b0000;
    cnt1 = 0;
    for (int i = 0; i < 4; i++) cnt4[i] = 0;
    tog1_exp = '0;
    tog4_exp = '0;
    test_reset();
    test_toggle_seq();
    test_hold();
    test_glitch();
    test_reset_dominance();
    test_width4();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/t_flip_flop.md
T_FLIP_FLOP -- requirements
Module: t_flip_flop

Interface
REQ-001 Parameter WIDTH, default 1: number of independent toggle bits; legal range 1..64.
REQ-002 Parameter RESET_VALUE, default all-zeros (WIDTH bits): value loaded into q on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 t  input  WIDTH  per-bit toggle request, sampled on rising clk.
REQ-006 q  output  WIDTH  registered flip-flop state.
REQ-007 qn  output  WIDTH  bitwise complement of q; may be left unconnected by the instantiating block.
REQ-008 toggled  output  WIDTH  registered per-bit flag: 1 for the cycle after bit i of q changed by toggle; may be left unconnected.

Function
REQ-009 At each rising clk with rstn=1, for each bit i: t[i]=1 -> q[i] <= ~q[i]; t[i]=0 -> q[i] holds.
REQ-010 q shall change only on rising clk; t changes between edges, including glitches, shall have no effect on q.
REQ-011 Latency: a t[i]=1 sampled at edge N is visible on q[i] immediately after edge N (one register stage, no extra pipeline).
REQ-012 t held at 1 for K consecutive edges shall toggle q[i] K times; q[i] at the end equals its start value XOR (K mod 2).
REQ-013 qn shall be combinational ~q at all times, including during reset.
REQ-014 toggled[i] shall be 1 after edge N only when rstn=1 and t[i]=1 at edge N; otherwise 0.
REQ-015 Bits shall be fully independent; any mix of toggling and holding bits in one cycle is legal.
REQ-016 Behaviour with X/Z on t is undefined; the bench shall drive t only with 0/1.

Reset
REQ-017 At a rising clk with rstn=0: q <= RESET_VALUE, toggled <= 0, regardless of t.
REQ-018 Reset shall dominate: t=1 coincident with rstn=0 shall not toggle.
REQ-019 Assertion of rstn between edges shall not alter q until the next rising clk (no asynchronous path).
REQ-020 Before the first reset edge q is unspecified; after one rising clk with rstn=0, q shall equal RESET_VALUE.
REQ-021 The first edge with rstn=1 shall apply normal toggle/hold per REQ-009.
REQ-022 Mid-operation reset shall override any toggle in progress on that edge.

Structure
REQ-023 Package t_flip_flop_pkg shall hold the constants TFF_DEFAULT_WIDTH (1) and TFF_MAX_WIDTH (64), plus a helper function returning the default reset vector.
REQ-024 Sub-module tff_cell (single-bit clk, rstn, t, reset value; outputs q, toggled) shall be instantiated WIDTH times by a generate loop in t_flip_flop.
REQ-025 No latches and no combinational loops; qn is the only combinational output.

Verification
REQ-026 rstn=0 for 2 clk edges with t=0 -> q=0, qn=1, toggled=0 after the first edge.
REQ-027 rstn=1, t=1 for 4 edges from q=0 -> q sequence 1,0,1,0, toggled=1 on each cycle.
REQ-028 rstn=1, t=0 for 5 edges -> q constant; toggled=0 throughout.
REQ-029 t pulsed high only between two rising edges (random 0-31 time-unit delays, clk period 10) -> q unchanged; a t level present at an edge toggles exactly once.
REQ-030 rstn=0 and t=1 at the same edge with q=1 -> q=0 (reset wins); next edge rstn=1, t=1 -> q=1.
REQ-031 WIDTH=4, RESET_VALUE=4'b1010, t=4'b0110 for one edge after reset -> q=4'b1100, toggled=4'b0110.
